// File: rtl/sram_rr_arbiter_if.sv
// Purpose: bundles both requester channels and the SRAM phy pins of sram_rr_arbiter.
// Latency: none; this file only declares wires and modports.
// Backpressure: busy0/busy1 tell a requester to hold its request stable.
// Ports: slave = arbiter view (requests and pin data in; busy, read return and phy controls out);
//        master = user/pin-side view (the mirror image).
interface sram_rr_arbiter_if #(
   parameter int DW = 8,
   parameter int AW = 19
);
   logic          en;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata0;
   logic [DW-1:0] wdata1;
   logic          req0;
   logic          req1;
   logic          we0;
   logic          we1;
   logic          busy0;
   logic          busy1;
   logic [DW-1:0] rdata0;
   logic [DW-1:0] rdata1;
   logic          valid0;
   logic          valid1;
   logic [AW-1:0] sram_addr;
   logic          sram_ce_n;
   logic          sram_we_n;
   logic          sram_oe_n;
   logic [DW-1:0] sram_dq_wr;
   logic          sram_dq_oe;
   logic [DW-1:0] sram_dq_rd;

   modport slave (
      input  en, addr0, addr1, wdata0, wdata1, req0, req1, we0, we1, sram_dq_rd,
      output busy0, busy1, rdata0, rdata1, valid0, valid1,
             sram_addr, sram_ce_n, sram_we_n, sram_oe_n, sram_dq_wr, sram_dq_oe
   );

   modport master (
      output en, addr0, addr1, wdata0, wdata1, req0, req1, we0, we1, sram_dq_rd,
      input  busy0, busy1, rdata0, rdata1, valid0, valid1,
             sram_addr, sram_ce_n, sram_we_n, sram_oe_n, sram_dq_wr, sram_dq_oe
   );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Purpose: round-robin share of one async SRAM phy between two requesters, with tagged read return.
// Latency: phy driven 1 cycle after acceptance; read data/valid RD_LAT+1 cycles after acceptance.
// Backpressure: busyx = reqx & ~gntx (combinational); a direction change costs one bubble cycle.
// Ports: clk, rst (synchronous, active-high); bus (slave modport) carries en, the two request
//        channels (addr/wdata/req/we in, busy/rdata/valid out) and the registered phy pins.
module sram_rr_arbiter #(
   parameter int DW     = 8,
   parameter int AW     = 19,
   parameter int RD_LAT = 1
) (
   input  logic               clk,
   input  logic               rst,
   sram_rr_arbiter_if.slave   bus
);

   typedef struct packed {
      logic rd;   // slot carries a read
      logic ch;   // channel that issued it
   } rd_tag_t;

   logic    prio;       // channel favoured when both request
   logic    prev_gnt;   // an access was granted last cycle
   logic    last_we;    // direction of the most recent grant (1 = write)
   rd_tag_t pipe [RD_LAT];

   logic any_req;
   logic win;
   logic win_we;
   logic bubble;
   logic gnt;
   logic gnt0;
   logic gnt1;

   always_comb begin
      any_req = bus.req0 | bus.req1;
      win     = (bus.req0 & bus.req1) ? prio : bus.req1;
      win_we  = win ? bus.we1 : bus.we0;
      // Only a grant in the immediately preceding cycle needs a turnaround;
      // an idle phy cycle already separates the two directions.
      bubble  = prev_gnt & (last_we != win_we);
      gnt     = ~rst & bus.en & any_req & ~bubble;
      gnt0    = gnt & ~win;
      gnt1    = gnt & win;
   end

   assign bus.busy0 = bus.req0 & ~gnt0;
   assign bus.busy1 = bus.req1 & ~gnt1;

   // Arbitration state and registered phy controls.
   always_ff @(posedge clk) begin
      if (rst) begin
         prio           <= 1'b0;
         prev_gnt       <= 1'b0;
         last_we        <= 1'b0;
         bus.sram_addr  <= '0;
         bus.sram_dq_wr <= '0;
         bus.sram_ce_n  <= 1'b1;
         bus.sram_we_n  <= 1'b1;
         bus.sram_oe_n  <= 1'b1;
         bus.sram_dq_oe <= 1'b0;
      end else begin
         prev_gnt <= gnt;
         if (gnt) begin
            prio          <= ~win;
            last_we       <= win_we;
            bus.sram_addr <= win ? bus.addr1 : bus.addr0;
            if (win_we) begin
               bus.sram_dq_wr <= win ? bus.wdata1 : bus.wdata0;
            end
            bus.sram_ce_n  <= 1'b0;
            bus.sram_we_n  <= ~win_we;
            bus.sram_oe_n  <= win_we;
            bus.sram_dq_oe <= win_we;
         end else begin
            bus.sram_ce_n  <= 1'b1;
            bus.sram_we_n  <= 1'b1;
            bus.sram_oe_n  <= 1'b1;
            bus.sram_dq_oe <= 1'b0;
         end
      end
   end

   // Read tag pipeline: stage 0 is live in the phy-drive cycle, the tail stage
   // is live in the cycle whose closing edge samples sram_dq_rd. Not cleared by
   // en, so reads already on the phy still return.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) begin
            pipe[i] <= '0;
         end
      end else begin
         pipe[0] <= '{rd: gnt & ~win_we, ch: win};
         for (int i = 1; i < RD_LAT; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   // Read return: only the tagged channel captures data and strobes valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rdata0 <= '0;
         bus.rdata1 <= '0;
         bus.valid0 <= 1'b0;
         bus.valid1 <= 1'b0;
      end else begin
         bus.valid0 <= pipe[RD_LAT-1].rd & ~pipe[RD_LAT-1].ch;
         bus.valid1 <= pipe[RD_LAT-1].rd &  pipe[RD_LAT-1].ch;
         if (pipe[RD_LAT-1].rd & ~pipe[RD_LAT-1].ch) begin
            bus.rdata0 <= bus.sram_dq_rd;
         end
         if (pipe[RD_LAT-1].rd & pipe[RD_LAT-1].ch) begin
            bus.rdata1 <= bus.sram_dq_rd;
         end
      end
   end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Purpose: directed self-checking bench for sram_rr_arbiter at RD_LAT = 1, 3 and 2.
// Latency: inputs driven 1 ns after posedge, outputs sampled on the negedge of the same cycle.
// Backpressure: requests held stable while busy, as a real requester would.
module tb_sram_rr_arbiter;

   localparam int DW = 8;
   localparam int AW = 19;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   logic rst_c = 1'b1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   sram_rr_arbiter_if #(.DW(DW), .AW(AW)) bus_a ();
   sram_rr_arbiter_if #(.DW(DW), .AW(AW)) bus_b ();
   sram_rr_arbiter_if #(.DW(DW), .AW(AW)) bus_c ();

   sram_rr_arbiter #(.DW(DW), .AW(AW), .RD_LAT(1)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
   sram_rr_arbiter #(.DW(DW), .AW(AW), .RD_LAT(3)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));
   sram_rr_arbiter #(.DW(DW), .AW(AW), .RD_LAT(2)) dut_c (.clk(clk), .rst(rst_c), .bus(bus_c));

   // SRAM model for instance A (latency 1): combinational read of the driven address.
   logic [DW-1:0] mem_a [256];
   assign bus_a.sram_dq_rd = mem_a[bus_a.sram_addr[7:0]];
   always @(posedge clk) begin
      if (!bus_a.sram_ce_n && !bus_a.sram_we_n) mem_a[bus_a.sram_addr[7:0]] <= bus_a.sram_dq_wr;
   end

   // Instance B never returns data that matters.
   assign bus_b.sram_dq_rd = 8'h77;

   // Instance C (latency 2): data = low byte of the address driven one cycle earlier.
   logic [AW-1:0] addr_d_c = '0;
   always @(posedge clk) addr_d_c <= bus_c.sram_addr;
   assign bus_c.sram_dq_rd = addr_d_c[7:0];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic reset_a();
      rst_a = 1'b1;
      next_cyc();
      next_cyc();
      rst_a = 1'b0;
   endtask

   logic [7:0] exp_addr [4];
   logic       seen_valid;

   initial begin
      for (int i = 0; i < 256; i++) mem_a[i] = i[7:0];
      mem_a[8'h10] = 8'hA5;
      exp_addr[0] = 8'h20; exp_addr[1] = 8'h31; exp_addr[2] = 8'h22; exp_addr[3] = 8'h33;

      bus_a.en = 1'b1; bus_a.req0 = 0; bus_a.req1 = 0; bus_a.we0 = 0; bus_a.we1 = 0;
      bus_a.addr0 = '0; bus_a.addr1 = '0; bus_a.wdata0 = '0; bus_a.wdata1 = '0;
      bus_b.en = 1'b1; bus_b.req0 = 0; bus_b.req1 = 0; bus_b.we0 = 0; bus_b.we1 = 0;
      bus_b.addr0 = '0; bus_b.addr1 = '0; bus_b.wdata0 = '0; bus_b.wdata1 = '0;
      bus_c.en = 1'b1; bus_c.req0 = 0; bus_c.req1 = 0; bus_c.we0 = 0; bus_c.we1 = 0;
      bus_c.addr0 = '0; bus_c.addr1 = '0; bus_c.wdata0 = '0; bus_c.wdata1 = '0;

      // Reset state of instance A.
      next_cyc();
      next_cyc();
      smp();
      chk("rst_ce_n",  bus_a.sram_ce_n,  1);
      chk("rst_we_n",  bus_a.sram_we_n,  1);
      chk("rst_oe_n",  bus_a.sram_oe_n,  1);
      chk("rst_dq_oe", bus_a.sram_dq_oe, 0);
      chk("rst_addr",  bus_a.sram_addr,  0);
      chk("rst_dq_wr", bus_a.sram_dq_wr, 0);
      chk("rst_valid", {bus_a.valid1, bus_a.valid0}, 0);
      chk("rst_rdata", {bus_a.rdata1, bus_a.rdata0}, 0);
      next_cyc();
      rst_a = 1'b0;

      // Single read on ch0, RD_LAT=1.
      next_cyc();
      bus_a.req0 = 1; bus_a.we0 = 0; bus_a.addr0 = 19'h00010;
      smp(); chk("rd_busy0_c0", bus_a.busy0, 0);
      next_cyc();
      bus_a.req0 = 0;
      smp();
      chk("rd_addr_c1", bus_a.sram_addr, 19'h00010);
      chk("rd_oe_n_c1", bus_a.sram_oe_n, 0);
      chk("rd_valid0_c1", bus_a.valid0, 0);
      next_cyc();
      smp();
      chk("rd_valid0_c2", bus_a.valid0, 1);
      chk("rd_rdata0_c2", bus_a.rdata0, 8'hA5);
      chk("rd_valid1_c2", bus_a.valid1, 0);
      next_cyc();
      smp();
      chk("rd_valid0_c3", bus_a.valid0, 0);

      // Contention: both channels read, grants alternate starting at ch0.
      reset_a();
      for (int k = 0; k < 6; k++) begin
         next_cyc();
         bus_a.req0 = (k < 4); bus_a.req1 = (k < 4);
         bus_a.we0 = 0; bus_a.we1 = 0;
         bus_a.addr0 = (k < 2) ? 19'h20 : 19'h22;
         bus_a.addr1 = (k < 2) ? 19'h31 : 19'h33;
         smp();
         if (k < 4) begin
            chk($sformatf("ct_busy0_%0d", k), bus_a.busy0, (k % 2) == 1);
            chk($sformatf("ct_busy1_%0d", k), bus_a.busy1, (k % 2) == 0);
         end
         if (k >= 1 && k <= 4) begin
            chk($sformatf("ct_addr_%0d", k), bus_a.sram_addr, exp_addr[k-1]);
            chk($sformatf("ct_ce_n_%0d", k), bus_a.sram_ce_n, 0);
         end
         if (k >= 2) begin
            chk($sformatf("ct_valid0_%0d", k), bus_a.valid0, ((k - 2) % 2) == 0);
            chk($sformatf("ct_valid1_%0d", k), bus_a.valid1, ((k - 2) % 2) == 1);
            if ((k - 2) % 2 == 0) chk($sformatf("ct_rdata0_%0d", k), bus_a.rdata0, exp_addr[k-2]);
            else                  chk($sformatf("ct_rdata1_%0d", k), bus_a.rdata1, exp_addr[k-2]);
         end
      end
      bus_a.req0 = 0; bus_a.req1 = 0;

      // Turnaround: write 0x3C to addr 5, then read it back.
      reset_a();
      next_cyc();
      bus_a.req0 = 1; bus_a.we0 = 1; bus_a.addr0 = 19'd5; bus_a.wdata0 = 8'h3C;
      smp(); chk("ta_busy0_c0", bus_a.busy0, 0);
      next_cyc();
      bus_a.we0 = 0;
      smp();
      chk("ta_busy0_c1", bus_a.busy0, 1);
      chk("ta_we_n_c1",  bus_a.sram_we_n, 0);
      chk("ta_dq_oe_c1", bus_a.sram_dq_oe, 1);
      chk("ta_dq_wr_c1", bus_a.sram_dq_wr, 8'h3C);
      next_cyc();
      smp();
      chk("ta_busy0_c2", bus_a.busy0, 0);
      chk("ta_dq_oe_c2", bus_a.sram_dq_oe, 0);
      chk("ta_ce_n_c2",  bus_a.sram_ce_n, 1);
      next_cyc();
      bus_a.req0 = 0;
      smp();
      chk("ta_oe_n_c3", bus_a.sram_oe_n, 0);
      chk("ta_addr_c3", bus_a.sram_addr, 5);
      next_cyc();
      smp();
      chk("ta_valid0_c4", bus_a.valid0, 1);
      chk("ta_rdata0_c4", bus_a.rdata0, 8'h3C);

      // Gating: en=0 blocks everything, then ch0 wins first.
      reset_a();
      bus_a.en = 0;
      bus_a.req0 = 1; bus_a.req1 = 1; bus_a.we0 = 0; bus_a.we1 = 0;
      bus_a.addr0 = 19'h44; bus_a.addr1 = 19'h55;
      for (int k = 0; k < 3; k++) begin
         next_cyc();
         smp();
         chk($sformatf("en_busy0_%0d", k), bus_a.busy0, 1);
         chk($sformatf("en_busy1_%0d", k), bus_a.busy1, 1);
         chk($sformatf("en_ce_n_%0d", k),  bus_a.sram_ce_n, 1);
      end
      next_cyc();
      bus_a.en = 1;
      smp();
      chk("en_busy0_on", bus_a.busy0, 0);
      chk("en_busy1_on", bus_a.busy1, 1);
      next_cyc();
      bus_a.req0 = 0;
      smp();
      chk("en_addr_on", bus_a.sram_addr, 19'h44);
      chk("en_busy1_2", bus_a.busy1, 0);
      next_cyc();
      bus_a.req1 = 0;

      // Reset mid-flight, RD_LAT=3.
      rst_b = 1'b0;
      next_cyc();
      bus_b.req0 = 1; bus_b.we0 = 0; bus_b.addr0 = 19'd7;
      smp(); chk("mr_busy0_c0", bus_b.busy0, 0);
      next_cyc();
      bus_b.req0 = 0;
      smp(); chk("mr_addr_c1", bus_b.sram_addr, 7);
      next_cyc();
      rst_b = 1'b1; bus_b.req0 = 1;
      smp(); chk("mr_busy0_rst", bus_b.busy0, 1);
      next_cyc();
      rst_b = 1'b0; bus_b.req0 = 0;
      smp();
      chk("mr_ce_n",  bus_b.sram_ce_n, 1);
      chk("mr_we_n",  bus_b.sram_we_n, 1);
      chk("mr_oe_n",  bus_b.sram_oe_n, 1);
      chk("mr_dq_oe", bus_b.sram_dq_oe, 0);
      chk("mr_addr",  bus_b.sram_addr, 0);
      chk("mr_dq_wr", bus_b.sram_dq_wr, 0);
      chk("mr_rdata", {bus_b.rdata1, bus_b.rdata0}, 0);
      seen_valid = bus_b.valid0 | bus_b.valid1;
      for (int k = 0; k < 6; k++) begin
         next_cyc();
         smp();
         seen_valid = seen_valid | bus_b.valid0 | bus_b.valid1;
      end
      chk("mr_no_valid", seen_valid, 0);

      // RD_LAT=2 streaming: 8 back-to-back ch1 reads.
      rst_c = 1'b0;
      for (int k = 0; k < 12; k++) begin
         next_cyc();
         bus_c.req1 = (k < 8); bus_c.we1 = 0; bus_c.addr1 = 19'h40 + k;
         smp();
         if (k < 8) chk($sformatf("st_busy1_%0d", k), bus_c.busy1, 0);
         chk($sformatf("st_valid0_%0d", k), bus_c.valid0, 0);
         if (k >= 3 && k < 11) begin
            chk($sformatf("st_valid1_%0d", k), bus_c.valid1, 1);
            chk($sformatf("st_rdata1_%0d", k), bus_c.rdata1, 8'h40 + k - 3);
         end else begin
            chk($sformatf("st_valid1_%0d", k), bus_c.valid1, 0);
         end
      end
      bus_c.req1 = 0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sram_rr_arbiter.md
# sram_rr_arbiter

Two-channel round-robin arbiter that shares one asynchronous SRAM phy between two requesters, each with a valid/busy request handshake and a tagged read-return path. It sits between user logic (for example a DMA and a CPU-side port) and the top-level SRAM pins. The top level merges `sram_dq_wr`/`sram_dq_rd` into the inout pins using `sram_dq_oe`. The block adds registered phy outputs, direction-change turnaround bubbles and per-channel read routing through a latency pipeline.

## Interface
- `DW`, 8, data width
- `AW`, 19, address width
- `RD_LAT`, 1, phy read latency: cycles from phy-drive cycle to `sram_dq_rd` sample, ≥1
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `en` in 1: global enable; 0 blocks all new grants and forces `sram_ce_n`=1 in the next cycle
- `addr0`/`addr1` in AW: request address
- `wdata0`/`wdata1` in DW: write data
- `req0`/`req1` in 1: request valid
- `we0`/`we1` in 1: 1=write, 0=read
- `busy0`/`busy1` out 1: request not accepted this cycle
- `rdata0`/`rdata1` out DW: read data
- `valid0`/`valid1` out 1: one-cycle read-data strobe
- `sram_addr` out AW, `sram_ce_n` out 1, `sram_we_n` out 1, `sram_oe_n` out 1: phy controls, all registered
- `sram_dq_wr` out DW: write data to pins, registered
- `sram_dq_oe` out 1: 1 = FPGA drives the data bus, registered
- `sram_dq_rd` in DW: data from pins

## Operation
- Acceptance: a request on channel x is accepted in any cycle with `reqx`=1 and `busyx`=0. `busyx` = `reqx` & ~`gntx`, combinational. While busy, the requester holds `addr`/`we`/`wdata` stable.
- Grant, cycle by cycle:
  - No grant if `rst`=1, `en`=0, or the cycle is a turnaround bubble.
  - Otherwise, if exactly one channel requests, it is granted.
  - If both request, the channel named by priority pointer `prio` is granted.
- Pointer: after a grant to channel i, `prio` = 1-i. Reset value of `prio` is 0.
- Turnaround bubble: the previous cycle granted an access whose direction differs from the direction of the request that would win this cycle. During a bubble there are no grants and `prio` is unchanged, so the same winner is granted next cycle. Back-to-back same-direction accesses have no bubble.
- Phy issue, registered from the grant:
  - Granted read: `sram_ce_n`=0, `sram_oe_n`=0, `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr`=addr.
  - Granted write: `sram_ce_n`=0, `sram_we_n`=0, `sram_oe_n`=1, `sram_dq_oe`=1, `sram_dq_wr`=wdata.
  - No grant: `sram_ce_n`=1, `sram_we_n`=1, `sram_oe_n`=1, `sram_dq_oe`=0; `sram_addr` and `sram_dq_wr` hold their values.
- Read return:
  - A shift pipeline of depth RD_LAT carries {read flag, channel id} from the phy-drive cycle.
  - At the pipeline tail, `sram_dq_rd` is registered into `rdata` of the tagged channel, and that channel's `valid` pulses for one cycle.
  - The other channel's `rdata` holds its value.
  - Writes produce no valid.
- Reset values:
  - Phy: `sram_ce_n`=`sram_we_n`=`sram_oe_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_wr`=0.
  - User side: `rdata0`=`rdata1`=0, `valid0`=`valid1`=0.
  - Internal: pipeline cleared, last-direction = read, no previous grant.
- Reset mid-operation: in-flight reads are discarded and no valid is produced for them. `busyx` follows `reqx` while `rst`=1.
- Deasserting `en` does not flush the pipeline; reads already issued still return.

## Timing
- Cycle 0: request accepted. Cycle 1: phy driven. Cycle 1+RD_LAT: `valid`/`rdata` asserted. Total read latency is RD_LAT+1 cycles from acceptance (2 for the default).
- Throughput: one access per cycle for same-direction traffic. Each direction change costs one bubble cycle on the phy, during which all phy controls are inactive and `sram_dq_oe`=0.
- Simultaneous `valid` strobes on both channels are impossible; at most one read retires per cycle.

## Test plan
- Single reads, RD_LAT=1: after reset, ch0 reads addr 0x00010 with `sram_dq_rd` modelled as 0xA5 -> `busy0`=0 in cycle 0; `sram_addr`=0x00010 and `sram_oe_n`=0 in cycle 1; `valid0`=1 with `rdata0`=0xA5 in cycle 2; `valid1` stays 0.
- Contention: both channels hold reads for 4 cycles -> grants alternate ch0, ch1, ch0, ch1 with no bubbles; each `busy` is high exactly on the other channel's grant cycles; valids alternate by channel.
- Turnaround: ch0 writes 0x3C to addr 5, then immediately reads addr 5 -> phy write in cycle 1; bubble in cycle 2 with `sram_dq_oe`=0 and `sram_ce_n`=1; read driven in cycle 3; `rdata0`=0x3C with `valid0` in cycle 4.
- Gating: `en`=0 with both channels requesting for 3 cycles -> `busy0`=`busy1`=1 and `sram_ce_n`=1 throughout; after `en` rises, ch0 is granted first because `prio`=0.
- Reset mid-flight, RD_LAT=3: read accepted in cycle 0, `rst` pulsed in cycle 2 -> no `valid` ever; all outputs at their reset values in cycle 3.
- RD_LAT=2 streaming: 8 back-to-back ch1 reads -> 8 `valid1` pulses in consecutive cycles starting at cycle 3, data matching addresses in order.
